// File: rtl/clk_pkg.sv
// Shared state encoding and width helper for the digital-clock timebase/mode control.
package clk_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_SET_H = 2'b01,
        ST_SET_M = 2'b10
    } state_t;

    function automatic int unsigned cnt_w(input int unsigned n);
        return $clog2(n) + 32'd1;
    endfunction

endpackage

// File: rtl/div_strobe.sv
// Divide-by-N event counter: STB is high for one CLK after every N-th EN cycle.
module div_strobe
    import clk_pkg::*;
#(
    parameter int unsigned N = 2
) (
    input  logic CLK,
    input  logic RSTN,
    input  logic EN,
    input  logic CLR,
    output logic STB
);

    localparam int unsigned W    = cnt_w(N);
    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] cnt;

    // A wrap coinciding with CLR still strobes; callers gate EN when it must not.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            cnt <= '0;
            STB <= 1'b0;
        end else begin
            STB <= EN && (cnt == LAST);
            if (CLR) begin
                cnt <= '0;
            end else if (EN) begin
                cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
            end
        end
    end

endmodule

// File: rtl/tick_sched_ctrl.sv
// Timebase strobes and RUN/SET mode FSM of the digital clock: 1 Hz ticks, scan
// strobes, blink phase and hour/minute increments with auto-repeat.
module tick_sched_ctrl
    import clk_pkg::*;
#(
    parameter int unsigned MS_PER_SEC = 1000,
    parameter int unsigned SCAN_MS    = 2,
    parameter int unsigned BLINK_MS   = 500,
    parameter int unsigned RPT_DLY_MS = 600,
    parameter int unsigned RPT_MS     = 150
) (
    input  logic       CLK,
    input  logic       RSTN,
    input  logic       CLK1M,
    input  logic       MODE_P,
    input  logic       UP_P,
    input  logic       UP_LVL,
    output logic       TICK_1HZ,
    output logic       SCAN_EN,
    output logic       BLINK,
    output logic [1:0] SET_SEL,
    output logic       INC_HOUR,
    output logic       INC_MIN
);

    localparam int unsigned RW = cnt_w(RPT_DLY_MS);
    localparam int unsigned IW = cnt_w(RPT_MS);

    state_t state, state_nx;

    logic          clk1m_d;
    logic          ms_t;
    logic          in_set;
    logic          enter_set_h;
    logic          leave_set;
    logic          up_acc;
    logic          ms_en;
    logic          ms_clr;
    logic          blink_en;
    logic          blink_clr;
    logic          blink_stb;
    logic          rpt_step;
    logic          rpt_armed;
    logic          rpt_fire;
    logic          inc_req;
    logic [RW-1:0] rpt_cnt;
    logic [IW-1:0] rpt_iv;
    logic          blink_q;
    logic          inc_hour_q;
    logic          inc_min_q;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            clk1m_d <= 1'b0;
        end else begin
            clk1m_d <= CLK1M;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state <= ST_RUN;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (MODE_P) begin
            case (state)
                ST_RUN:   state_nx = ST_SET_H;
                ST_SET_H: state_nx = ST_SET_M;
                default:  state_nx = ST_RUN;
            endcase
        end
    end

    always_comb begin
        ms_t        = CLK1M && !clk1m_d;
        in_set      = (state != ST_RUN);
        enter_set_h = MODE_P && (state == ST_RUN);
        leave_set   = MODE_P && (state == ST_SET_M);
        up_acc      = UP_P && !MODE_P && in_set;
        ms_en       = ms_t && (state == ST_RUN);
        ms_clr      = enter_set_h || leave_set;
        blink_clr   = enter_set_h || up_acc;
        blink_en    = ms_t && in_set && !blink_clr;
        rpt_step    = ms_t && UP_LVL && in_set;
        rpt_armed   = (rpt_cnt == RW'(RPT_DLY_MS));
        rpt_fire    = rpt_step && (rpt_armed ? (rpt_iv == IW'(RPT_MS - 1))
                                             : (rpt_cnt == RW'(RPT_DLY_MS - 1)));
        inc_req     = up_acc || (rpt_fire && !MODE_P);
    end

    div_strobe #(.N(MS_PER_SEC)) u_ms (
        .CLK  (CLK),
        .RSTN (RSTN),
        .EN   (ms_en),
        .CLR  (ms_clr),
        .STB  (TICK_1HZ)
    );

    div_strobe #(.N(SCAN_MS)) u_scan (
        .CLK  (CLK),
        .RSTN (RSTN),
        .EN   (ms_t),
        .CLR  (1'b0),
        .STB  (SCAN_EN)
    );

    div_strobe #(.N(BLINK_MS)) u_blink (
        .CLK  (CLK),
        .RSTN (RSTN),
        .EN   (blink_en),
        .CLR  (blink_clr),
        .STB  (blink_stb)
    );

    // Delay phase saturates at RPT_DLY_MS, then rpt_iv paces the repeats.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            rpt_cnt <= '0;
            rpt_iv  <= '0;
        end else if (!in_set || !UP_LVL) begin
            rpt_cnt <= '0;
            rpt_iv  <= '0;
        end else if (rpt_step) begin
            if (!rpt_armed) begin
                rpt_cnt <= rpt_cnt + RW'(1);
            end else begin
                rpt_iv <= rpt_fire ? '0 : rpt_iv + IW'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            blink_q    <= 1'b0;
            inc_hour_q <= 1'b0;
            inc_min_q  <= 1'b0;
        end else begin
            inc_hour_q <= inc_req && (state == ST_SET_H);
            inc_min_q  <= inc_req && (state == ST_SET_M);
            if (state_nx == ST_RUN) begin
                blink_q <= 1'b0;
            end else if (blink_clr) begin
                blink_q <= 1'b1;
            end else if (blink_stb) begin
                blink_q <= ~blink_q;
            end
        end
    end

    assign SET_SEL  = state;
    assign BLINK    = blink_q;
    assign INC_HOUR = inc_hour_q;
    assign INC_MIN  = inc_min_q;

endmodule
